// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory-port arbiter.
//   - arb_state_e : controller state encoding (IDLE = 1'b0, BUSY = 1'b1)
//   - SIZE_*      : access-size codes carried on req_size / mem_size
package mem_port_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory-port arbiter.
// The search starts at port 'ptr' and wraps; the first requesting port that is
// not excluded wins. With ptr tied to zero this is plain lowest-index priority.
// Ports:
//   req     in   NUM_PORTS  request vector
//   exclude in   NUM_PORTS  ports that may not win this cycle
//   ptr     in   IDX_W      port with highest priority
//   grant   out  NUM_PORTS  one-hot winner (all zero when nobody eligible)
//   idx     out  IDX_W      binary index of the winner
//   valid   out  1          some port won
module arb_pick #(
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned IDX_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [NUM_PORTS-1:0] exclude,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] grant,
    output logic [IDX_W-1:0]     idx,
    output logic                 valid
);

    logic [NUM_PORTS-1:0] avail;

    assign avail = req & ~exclude;
    assign valid = |avail;

    // Walk from the lowest to the highest priority slot backwards so the last
    // assignment is the highest-priority eligible port; no "found" flag needed.
    always_comb begin
        int pos;
        grant = '0;
        idx   = '0;
        pos   = 0;
        for (int k = int'(NUM_PORTS) - 1; k >= 0; k--) begin
            pos = (int'(ptr) + k) % int'(NUM_PORTS);
            if (avail[pos]) begin
                grant      = '0;
                grant[pos] = 1'b1;
                idx        = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbiter granting NUM_PORTS pipeline requestors the single unified memory port
// (default: port 0 = memory stage, port 1 = fetch). The grant is held for the
// whole multi-cycle access; each access takes at least two cycles and is
// followed by one idle bubble.
//
// Build option ARB_ROUND_ROBIN_EN: when defined, a rotating priority pointer
// (last winner + 1) is kept; otherwise fixed priority, lowest index wins.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   req_re/we    per-port read/write request (write wins if both set)
//   req_addr     flattened addresses, port i at [i*ADDR_W +: ADDR_W]
//   req_size     flattened sizes, port i at [i*2 +: 2]
//   flush        taken branch/jump this cycle
//   mem_ready    memory finishes the current access this cycle
//   mem_addr/re/we/size/port  registered command to memory, owner index
//   ack          one-cycle completion pulse to the owner
//   stall        port must hold its request and stall
//   stall_flush  flush must be held off (non-flushable access in flight)
//   busy         access in flight
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned          ADDR_W     = 32,
    parameter int unsigned          NUM_PORTS  = 2,
    parameter logic [NUM_PORTS-1:0] FLUSH_MASK = 2'b10
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_re,
    input  logic [NUM_PORTS-1:0]          req_we,
    input  logic [NUM_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [NUM_PORTS*2-1:0]        req_size,
    input  logic                          flush,
    input  logic                          mem_ready,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic                          mem_re,
    output logic                          mem_we,
    output logic [1:0]                    mem_size,
    output logic [$clog2(NUM_PORTS)-1:0]  mem_port,
    output logic [NUM_PORTS-1:0]          ack,
    output logic [NUM_PORTS-1:0]          stall,
    output logic                          stall_flush,
    output logic                          busy
);

    localparam int unsigned IDX_W = $clog2(NUM_PORTS);

    arb_state_e           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic                 cancelled_q, cancelled_d;
    logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
    logic                 mem_re_q, mem_re_d;
    logic                 mem_we_q, mem_we_d;
    logic [1:0]           mem_size_q, mem_size_d;
    logic [IDX_W-1:0]     mem_port_q, mem_port_d;

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] exclude;
    logic [NUM_PORTS-1:0] pick_grant;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_valid;
    logic                 owner_flushable;
    logic                 flush_owner;
    logic [ADDR_W-1:0]    win_addr;
    logic [1:0]           win_size;
    logic                 win_re;
    logic                 win_we;

    assign req             = req_re | req_we;
    assign owner_flushable = |(grant_q & FLUSH_MASK);
    // A flush kills the owner's result only if the owner is a flushable port.
    assign flush_owner     = flush & owner_flushable;

    // Flushable ports are not allowed to start an access during a flush.
    assign exclude = flush ? FLUSH_MASK : '0;

    // Fields of the selected requestor; write wins over read.
    assign win_addr = req_addr[int'(pick_idx)*int'(ADDR_W) +: ADDR_W];
    assign win_size = req_size[int'(pick_idx)*2 +: 2];
    assign win_we   = req_we[pick_idx];
    assign win_re   = req_re[pick_idx] & ~req_we[pick_idx];

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (state_q == IDLE && pick_valid) begin
            if (pick_idx == IDX_W'(NUM_PORTS - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = pick_idx + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: the search always starts at port 0.
    logic [IDX_W-1:0] ptr_q;
    assign ptr_q = '0;
`endif

    arb_pick #(
        .NUM_PORTS (NUM_PORTS),
        .IDX_W     (IDX_W)
    ) u_pick (
        .req     (req),
        .exclude (exclude),
        .ptr     (ptr_q),
        .grant   (pick_grant),
        .idx     (pick_idx),
        .valid   (pick_valid)
    );

    // Next-state and acknowledge logic.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cancelled_d = cancelled_q;
        mem_addr_d  = mem_addr_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_size_d  = mem_size_q;
        mem_port_d  = mem_port_q;
        ack         = '0;

        unique case (state_q)
            IDLE: begin
                // mem_ready is meaningless here and ignored.
                if (pick_valid) begin
                    state_d     = BUSY;
                    grant_d     = pick_grant;
                    cancelled_d = 1'b0;
                    mem_addr_d  = win_addr;
                    mem_re_d    = win_re;
                    mem_we_d    = win_we;
                    mem_size_d  = win_size;
                    mem_port_d  = pick_idx;
                end
            end
            BUSY: begin
                // The access always runs to completion; a flush only drops its result.
                if (flush_owner) begin
                    cancelled_d = 1'b1;
                end
                if (mem_ready) begin
                    if (!cancelled_q && !flush_owner) begin
                        ack = grant_q;
                    end
                    state_d     = IDLE;
                    grant_d     = '0;
                    cancelled_d = 1'b0;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            cancelled_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_size_q  <= '0;
            mem_port_q  <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cancelled_q <= cancelled_d;
            mem_addr_q  <= mem_addr_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_size_q  <= mem_size_d;
            mem_port_q  <= mem_port_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_re      = mem_re_q;
    assign mem_we      = mem_we_q;
    assign mem_size    = mem_size_q;
    assign mem_port    = mem_port_q;
    assign busy        = (state_q == BUSY);
    assign stall       = req & ~ack;
    assign stall_flush = flush & busy & ~owner_flushable;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (NUM_PORTS = 2, ADDR_W = 32).
// Expected memory commands are queued when requests are driven and popped when
// the arbiter issues a command.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic [1:0]  req_re;
    logic [1:0]  req_we;
    logic [31:0] addr0, addr1;
    logic [1:0]  size0, size1;
    logic [63:0] req_addr;
    logic [3:0]  req_size;
    logic        flush;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [0:0]  mem_port;
    logic [1:0]  ack;
    logic [1:0]  stall;
    logic        stall_flush;
    logic        busy;

    assign req_addr = {addr1, addr0};
    assign req_size = {size1, size0};

    mem_port_arbiter #(
        .ADDR_W     (32),
        .NUM_PORTS  (2),
        .FLUSH_MASK (2'b10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_re      (req_re),
        .req_we      (req_we),
        .req_addr    (req_addr),
        .req_size    (req_size),
        .flush       (flush),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .mem_size    (mem_size),
        .mem_port    (mem_port),
        .ack         (ack),
        .stall       (stall),
        .stall_flush (stall_flush),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        re;
        logic        we;
        logic [1:0]  size;
        int          port;
    } cmd_t;

    cmd_t exp_q[$];
    int   nvec = 0;
    int   nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Expected command for port p, derived from what the bench is driving.
    task automatic push_cmd(input int p);
        cmd_t e;
        e.addr = (p == 0) ? addr0 : addr1;
        e.size = (p == 0) ? size0 : size1;
        e.we   = req_we[p];
        e.re   = req_re[p] & ~req_we[p];
        e.port = p;
        exp_q.push_back(e);
    endtask

    // Wait for the next command, compare it, answer with mem_ready 'delay'
    // cycles after the command, optionally pulse flush in cycle 'flush_at'.
    task automatic serve(input int delay, input int flush_at, input logic [1:0] exp_ack,
                         input logic exp_sf, input bit drop);
        int   waited;
        cmd_t e;
        waited = 0;
        while (!busy && waited < 20) begin
            tick();
            waited++;
        end
        check("grant_timeout", {63'd0, busy}, 64'd1);
        if (!busy) return;
        if (exp_q.size() == 0) begin
            check("sb_underflow", 64'd1, 64'd0);
            return;
        end
        e = exp_q.pop_front();
        check("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
        check("mem_re", {63'd0, mem_re}, {63'd0, e.re});
        check("mem_we", {63'd0, mem_we}, {63'd0, e.we});
        check("mem_size", {62'd0, mem_size}, {62'd0, e.size});
        check("mem_port", {63'd0, mem_port}, 64'(e.port));
        for (int k = 0; k <= delay; k++) begin
            if (k > 0) tick();
            flush     = (k == flush_at);
            mem_ready = (k == delay);
            #1;
            if (k == flush_at) check("stall_flush", {63'd0, stall_flush}, {63'd0, exp_sf});
            check("addr_hold", {32'd0, mem_addr}, {32'd0, e.addr});
            if (k == delay) begin
                check("ack", {62'd0, ack}, {62'd0, exp_ack});
                check("stall_ack", {62'd0, stall}, {62'd0, (req_re | req_we) & ~exp_ack});
            end else begin
                check("ack_wait", {62'd0, ack}, 64'd0);
                check("stall_wait", {62'd0, stall}, {62'd0, req_re | req_we});
            end
        end
        tick();
        flush     = 1'b0;
        mem_ready = 1'b0;
        // Bubble cycle after completion.
        check("bubble_busy", {63'd0, busy}, 64'd0);
        check("bubble_strb", {62'd0, mem_re, mem_we}, 64'd0);
        if (drop) begin
            req_re[e.port] = 1'b0;
            req_we[e.port] = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_re = '0; req_we = '0; flush = 1'b0; mem_ready = 1'b0;
        addr0 = '0; addr1 = '0; size0 = SIZE_WORD; size1 = SIZE_WORD;
        tick();
        #1;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_cmd", {30'd0, mem_addr, mem_re, mem_we}, 64'd0);
        check("rst_ack", {62'd0, ack}, 64'd0);
        rst = 1'b0;
        tick();

        // Both ports read together: port 0 first, port 1 after a bubble.
        addr0 = 32'h100; addr1 = 32'h200; req_re = 2'b11;
        push_cmd(0); push_cmd(1);
        #1 check("stall_both", {62'd0, stall}, 64'd3);
        serve(2, -1, 2'b01, 1'b0, 1'b1);
        serve(2, -1, 2'b10, 1'b0, 1'b1);

        // Write word, mem_ready in the command cycle.
        addr0 = 32'h40; size0 = SIZE_WORD; req_we = 2'b01;
        push_cmd(0);
        serve(0, -1, 2'b01, 1'b0, 1'b1);

        // Both strobes: write wins.
        addr0 = 32'h44; size0 = SIZE_HALF; req_re = 2'b01; req_we = 2'b01;
        push_cmd(0);
        serve(1, -1, 2'b01, 1'b0, 1'b1);

        // Fetch cancelled by flush; access completes without ack.
        addr1 = 32'h300; size1 = SIZE_WORD; req_re = 2'b10;
        push_cmd(1);
        serve(3, 0, 2'b00, 1'b0, 1'b1);

        // Data access: flush held off, ack still delivered.
        addr0 = 32'h80; size0 = SIZE_BYTE; req_re = 2'b01;
        push_cmd(0);
        serve(2, 1, 2'b01, 1'b1, 1'b1);

        // Flush coinciding with mem_ready for a fetch: ack suppressed.
        addr1 = 32'h304; req_re = 2'b10;
        push_cmd(1);
        serve(1, 1, 2'b00, 1'b0, 1'b1);

        // Flush in IDLE excludes the fetch for that cycle.
        addr1 = 32'h308; req_re = 2'b10; flush = 1'b1;
        #1 check("flush_idle_stall", {62'd0, stall}, 64'd2);
        tick();
        check("flush_idle_excl", {63'd0, busy}, 64'd0);
        flush = 1'b0;
        push_cmd(1);
        serve(1, -1, 2'b10, 1'b0, 1'b1);

        // Flush in IDLE does not hold off the data port.
        addr0 = 32'h90; size0 = SIZE_WORD; req_re = 2'b01; flush = 1'b1;
        push_cmd(0);
        serve(1, -1, 2'b01, 1'b0, 1'b1);

        // Continuous requests from both ports, priority pointer fresh from reset.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        addr0 = 32'h1000; addr1 = 32'h2000; size0 = SIZE_WORD; size1 = SIZE_WORD;
        req_re = 2'b11;
        for (int n = 0; n < 6; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            push_cmd(n % 2);
`else
            push_cmd(0);
`endif
        end
        for (int n = 0; n < 6; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            serve(1, -1, (n % 2 == 0) ? 2'b01 : 2'b10, 1'b0, 1'b0);
`else
            serve(1, -1, 2'b01, 1'b0, 1'b0);
`endif
        end
        req_re = 2'b00;
        tick();

        // Reset in the middle of an access.
        addr0 = 32'h500; req_we = 2'b01;
        tick();
        check("pre_rst_busy", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_cmd", {30'd0, mem_addr, mem_re, mem_we}, 64'd0);
        check("midrst_port", {63'd0, mem_port}, 64'd0);
        tick();
        rst = 1'b0;
        push_cmd(0);
        serve(1, -1, 2'b01, 1'b0, 1'b1);

        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
